mem_arb: RTL and testbench

- Two-requester arbiter sharing one single-port memory between the instruction-fetch path and the load/store path of the core.
- Sits between the core's fetch/LSU front-ends and the unified memory.
- Sequences one outstanding transaction at a time through a 3-state FSM.
- Gives the LSU priority, with a starvation guard that protects fetch.

---
 rtl/mem_arb.sv | 198 +++++++++++++++++++
 tb/tb_mem_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-requester (fetch / load-store) arbiter for one single-port memory
//
// Purpose: Sequences one memory transaction at a time (IDLE -> REQ -> RSP).
//   The LSU wins contested cycles unless fetch has lost STARVE_MAX contests
//   in a row, in which case fetch is forced through.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a transaction that
//   spends TIMEOUT_CYCLES in REQ+RSP. The owner then gets an error response.
//   Without the macro the arbiter waits indefinitely and if_err/lsu_err are 0.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr                 fetch request in
//   if_gnt/if_rvalid/if_rdata/if_err       fetch grant and response out
//   lsu_req/lsu_we/lsu_addr/lsu_wdata/lsu_be   load/store request in
//   lsu_gnt/lsu_rvalid/lsu_rdata/lsu_err   load/store grant and response out
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be   registered memory request out
//   mem_gnt/mem_rvalid/mem_rdata   memory handshake and response in
module mem_arb #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_MAX     = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,
    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [3:0]            lsu_be,
    output logic                  lsu_gnt,
    output logic                  lsu_rvalid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  lsu_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;     // 1 = LSU owns the transaction
    logic [3:0]            starve_q, starve_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_be_q, mem_be_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    logic                  both_req;
    logic                  lsu_wins;
    logic                  resp_valid;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] resp_data;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_gnt      = 1'b0;
        lsu_gnt     = 1'b0;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;
        resp_data   = '0;

        both_req = if_req && lsu_req;
        // Fetch only beats a contending LSU once it has been starved enough.
        lsu_wins = lsu_req && !(if_req && (starve_q == STARVE_LIM));

        case (state_q)
            IDLE: begin
                if (if_req || lsu_req) begin
                    if_gnt    = !lsu_wins;
                    lsu_gnt   = lsu_wins;
                    owner_d   = lsu_wins;
                    mem_req_d = 1'b1;
                    state_d   = REQ;
                    if (lsu_wins) begin
                        mem_we_d    = lsu_we;
                        mem_addr_d  = lsu_addr;
                        mem_wdata_d = lsu_wdata;
                        mem_be_d    = lsu_be;
                        if (both_req) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = 4'hF;
                        starve_d    = 4'd0;
                    end
                end
            end
            REQ: begin
                // A response in the grant cycle is illegal and ignored.
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = RSP;
                end
            end
            RSP: begin
                if (mem_rvalid) begin
                    resp_valid = 1'b1;
                    resp_data  = mem_rdata;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef MEM_ARB_TIMEOUT_EN
        // Counter sits at zero in IDLE, so it starts from zero on entering REQ.
        tmo_d = (state_q == IDLE) ? '0 : tmo_q + TW'(1);
        if ((state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES))
            && !((state_q == RSP) && mem_rvalid)) begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            resp_data  = '0;
            mem_req_d  = 1'b0;
            state_d    = IDLE;
        end
`endif

        // Nothing reaches a requester while reset is asserted.
        if (rst) begin
            if_gnt     = 1'b0;
            lsu_gnt    = 1'b0;
            resp_valid = 1'b0;
            resp_err   = 1'b0;
        end
    end

    assign if_rvalid  = resp_valid && !owner_q;
    assign lsu_rvalid = resp_valid && owner_q;
    assign if_err     = resp_err && !owner_q;
    assign lsu_err    = resp_err && owner_q;
    assign if_rdata   = if_rvalid ? resp_data : '0;
    assign lsu_rdata  = lsu_rvalid ? resp_data : '0;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            starve_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'd0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb (transaction model plus directed vectors)
module tb_mem_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 3;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_rvalid, if_err;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          lsu_req, lsu_we, lsu_gnt, lsu_rvalid, lsu_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [3:0]    lsu_be;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_be;

    always #5 clk = ~clk;

    mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(SM), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_be(lsu_be), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .lsu_err(lsu_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the rising edge; the responder drives at +1.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // ---------------- transaction-level reference model ----------------
    bit            chk_en = 0;
    bit            m_busy = 0;       // a transaction is in flight
    bit            m_issued = 0;     // its memory request is still outstanding
    bit            m_lsu = 0;        // owner is the LSU
    int            m_starve = 0;     // contested LSU wins since fetch last won
    int            m_age = 0;        // cycles spent past the grant cycle
    logic          m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [3:0]    m_be = '0;
    bit            log_en = 0;
    byte           glog[$];

    always @(negedge clk) begin
        if (chk_en) begin
            bit            e_ig, e_lg, e_irv, e_lrv, e_ierr, e_lerr, pick_lsu, rd_dc, tmo;
            logic [DW-1:0] e_ird, e_lrd;
            e_ig = 0; e_lg = 0; e_irv = 0; e_lrv = 0; e_ierr = 0; e_lerr = 0;
            e_ird = '0; e_lrd = '0; rd_dc = 0; tmo = 0; pick_lsu = 0;

            chk("mem_req", mem_req, m_busy && m_issued);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_be", mem_be, m_be);

            if (log_en && if_gnt) glog.push_back("I");
            if (log_en && lsu_gnt) glog.push_back("L");

            if (rst) begin
                m_busy = 0; m_issued = 0; m_lsu = 0; m_starve = 0;
                m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
            end else if (!m_busy) begin
                if (if_req || lsu_req) begin
                    pick_lsu = lsu_req && !(if_req && m_starve >= SM);
                    if (pick_lsu && if_req) m_starve = m_starve + 1;
                    else if (!pick_lsu) m_starve = 0;
                    e_ig = !pick_lsu; e_lg = pick_lsu;
                    m_busy = 1; m_issued = 1; m_lsu = pick_lsu; m_age = 0;
                    m_we    = pick_lsu ? lsu_we : 1'b0;
                    m_addr  = pick_lsu ? lsu_addr : if_addr;
                    m_wdata = pick_lsu ? lsu_wdata : '0;
                    m_be    = pick_lsu ? lsu_be : 4'hF;
                end
            end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                tmo = (m_age == TO) && !(!m_issued && mem_rvalid);
`endif
                if (tmo) begin
                    e_irv = !m_lsu; e_lrv = m_lsu; e_ierr = !m_lsu; e_lerr = m_lsu;
                    m_busy = 0; m_issued = 0;
                end else if (m_issued) begin
                    if (mem_gnt) m_issued = 0;
                end else if (mem_rvalid) begin
                    e_irv = !m_lsu; e_lrv = m_lsu;
                    if (m_lsu) e_lrd = mem_rdata; else e_ird = mem_rdata;
                    rd_dc = m_lsu && m_we;
                    m_busy = 0;
                end
                m_age = m_age + 1;
            end

            chk("if_gnt", if_gnt, e_ig);
            chk("lsu_gnt", lsu_gnt, e_lg);
            chk("if_rvalid", if_rvalid, e_irv);
            chk("lsu_rvalid", lsu_rvalid, e_lrv);
            chk("if_err", if_err, e_ierr);
            chk("lsu_err", lsu_err, e_lerr);
            chk("if_rdata", if_rdata, e_ird);
            if (!rd_dc) chk("lsu_rdata", lsu_rdata, e_lrd);
        end
    end

    // ---------------- memory responder ----------------
    bit            mem_auto = 1;
    int            gnt_wait = 0;
    logic [DW-1:0] rsp_data = '0;

    initial begin
        int  wcnt;
        bit  fire, waiting;
        wcnt = 0;
        forever begin
            @(negedge clk);
            fire    = mem_req && mem_gnt;
            waiting = mem_req && !mem_gnt;
            @(posedge clk);
            #1;
            if (mem_auto) begin
                mem_rvalid = fire;
                mem_rdata  = fire ? rsp_data : '0;
                wcnt       = waiting ? wcnt + 1 : 0;
                mem_gnt    = mem_req && (wcnt >= gnt_wait);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        string exp_order;
        int    n;
        rst = 1; if_req = 0; if_addr = '0;
        lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_be = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1;
        @(negedge clk);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_be", mem_be, 0);
        cyc(); rst = 0;
        cyc();

        // Fetch only, zero-wait memory
        rsp_data = 32'h0000_0013;
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        chk("t1_if_gnt", if_gnt, 1);
        chk("t1_lsu_gnt", lsu_gnt, 0);
        cyc(); if_req = 0;
        @(negedge clk);
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_be", mem_be, 4'hF);
        cyc();
        @(negedge clk);
        chk("t1_if_rvalid", if_rvalid, 1);
        chk("t1_if_rdata", if_rdata, 32'h13);
        chk("t1_lsu_rvalid", lsu_rvalid, 0);
        cyc();

        // Store with mem_gnt delayed 3 cycles
        gnt_wait = 3;
        lsu_req = 1; lsu_we = 1; lsu_addr = 32'h2000; lsu_wdata = 32'hDEAD_BEEF; lsu_be = 4'b0011;
        @(negedge clk);
        chk("t2_lsu_gnt", lsu_gnt, 1);
        cyc(); lsu_req = 0; lsu_we = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_mem_req_held", mem_req, 1);
            chk("t2_mem_addr", mem_addr, 32'h2000);
            chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("t2_mem_be", mem_be, 4'b0011);
            chk("t2_mem_we", mem_we, 1);
            chk("t2_no_early_ack", lsu_rvalid, 0);
            cyc();
        end
        @(negedge clk);
        chk("t2_mem_req_low", mem_req, 0);
        chk("t2_ack", lsu_rvalid, 1);
        cyc();
        @(negedge clk);
        chk("t2_single_ack", lsu_rvalid, 0);
        cyc();

        // Continuous contention: LSU, LSU, LSU, IF, LSU
        gnt_wait = 0; rsp_data = 32'h1234_5678;
        glog.delete(); log_en = 1;
        if_req = 1; if_addr = 32'h400; lsu_req = 1; lsu_addr = 32'h800; lsu_be = 4'hF;
        repeat (13) cyc();
        if_req = 0; lsu_req = 0;
        repeat (3) cyc();
        log_en = 0;
        exp_order = "LLLIL";
        chk("t3_grant_count", glog.size(), 5);
        for (int i = 0; i < 5 && i < glog.size(); i++)
            chk($sformatf("t3_grant_order_%0d", i), glog[i], exp_order[i]);

        // Reset while waiting in RSP, then a late response
        mem_auto = 0; mem_gnt = 0; mem_rvalid = 0;
        if_req = 1; if_addr = 32'h300;
        cyc(); if_req = 0; mem_gnt = 1;
        cyc(); mem_gnt = 0;
        cyc(); rst = 1;
        cyc(); rst = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("t4_if_rvalid", if_rvalid, 0);
        chk("t4_lsu_rvalid", lsu_rvalid, 0);
        chk("t4_mem_req", mem_req, 0);
        cyc(); mem_rvalid = 0;
        cyc();

        // Spurious mem_rvalid in IDLE and in REQ
        mem_rvalid = 1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        chk("t5_idle_spurious", lsu_rvalid | if_rvalid, 0);
        cyc(); mem_rvalid = 0;
        lsu_req = 1; lsu_we = 0; lsu_addr = 32'h40;
        cyc(); lsu_req = 0; mem_rvalid = 1;
        @(negedge clk);
        chk("t5_req_spurious", lsu_rvalid | if_rvalid, 0);
        cyc(); mem_rvalid = 0; mem_gnt = 1;
        cyc(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("t5_load_rvalid", lsu_rvalid, 1);
        chk("t5_load_rdata", lsu_rdata, 32'hA5A5_A5A5);
        cyc(); mem_rvalid = 0;
        cyc();

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout: granted but never answered
        if_req = 1; if_addr = 32'h500;
        cyc(); if_req = 0; mem_gnt = 1;
        cyc(); mem_gnt = 0;
        n = 2;
        while (n < 30) begin
            @(negedge clk);
            if (if_rvalid) break;
            cyc();
            n++;
        end
        chk("t6_timeout_cycle", n, 9);
        chk("t6_if_err", if_err, 1);
        chk("t6_if_rdata", if_rdata, 0);
        cyc(); mem_rvalid = 1;
        @(negedge clk);
        chk("t6_late_rvalid", if_rvalid, 0);
        cyc(); mem_rvalid = 0;
        cyc();
`else
        n = 0;
`endif

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
